mult_share_arbiter: RTL

//  Shares one combinational 4x4 array_multiplier among NREQ requesters.
//  - Round-robin arbitration with a valid/ready handshake per requester.
//  - Operands are registered into the multiplier; the product is registered out.
//  - One response channel returns the product and requester ID, with backpressure.
//  - Sits between client blocks needing occasional 4-bit products and the single

---
 rtl/mult_share_arbiter_pkg.sv | 33 +++
 rtl/mult_share_arbiter_array_multiplier.sv | 15 +
 rtl/mult_share_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and the round-robin pick helper for mult_share_arbiter.
package mult_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    CALC2 = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int OP_W_DEF = 4;
  localparam int NREQ_MAX = 8;

  // First set bit of valid, scanning ptr, ptr+1, ... modulo nreq; 0 when none set.
  function automatic int unsigned rr_pick(input int unsigned valid,
                                          input int unsigned ptr,
                                          input int unsigned nreq);
    int unsigned g;
    int unsigned idx;
    bit          found;
    g     = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ_MAX; k++) begin
      idx = (ptr + k) % nreq;
      if (!found && (k < nreq) && (((valid >> idx) & 32'd1) != 32'd0)) begin
        g     = idx;
        found = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_array_multiplier.sv
// Combinational 4x4 unsigned array multiplier: sum of shifted partial products.
module array_multiplier (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  always_comb begin
    p = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (b[i]) p = p + (8'(a) << i);
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin sharing of one array_multiplier among NREQ valid/ready requesters.
// Build option MULT_PIPE_EN: registers the multiplier output and adds state CALC2.
module mult_share_arbiter
  import mult_share_pkg::*;
#(
  parameter  int NREQ = 4,
  parameter  int OP_W = OP_W_DEF,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*OP_W-1:0] req_a,
  input  logic [NREQ*OP_W-1:0] req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [2*OP_W-1:0]    rsp_p,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 busy
);

  state_t              r_state;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_id;
  logic [OP_W-1:0]     r_a;
  logic [OP_W-1:0]     r_b;
  logic [ID_W-1:0]     w_g;
  logic [ID_W-1:0]     w_ptr_nxt;
  logic                w_any;
  logic [2*OP_W-1:0]   w_p;
`ifdef MULT_PIPE_EN
  logic [2*OP_W-1:0]   r_p;
`endif

  assign w_any     = |req_valid;
  assign w_g       = ID_W'(rr_pick(32'(req_valid), 32'(r_ptr), NREQ));
  assign w_ptr_nxt = (w_g == ID_W'(NREQ - 1)) ? '0 : w_g + ID_W'(1);
  assign busy      = (r_state != IDLE);

  // Grant is a single-cycle pulse decoded from IDLE and the live valids.
  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && w_any) req_ready[w_g] = 1'b1;
  end

  array_multiplier u_mult (
    .a (r_a),
    .b (r_b),
    .p (w_p)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      rsp_valid <= 1'b0;
      rsp_p     <= '0;
      rsp_id    <= '0;
`ifdef MULT_PIPE_EN
      r_p       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= req_a[int'(w_g)*OP_W +: OP_W];
            r_b     <= req_b[int'(w_g)*OP_W +: OP_W];
            r_id    <= w_g;
            r_ptr   <= w_ptr_nxt;
            r_state <= CALC;
          end
        end
        CALC: begin
`ifdef MULT_PIPE_EN
          r_p       <= w_p;
          r_state   <= CALC2;
`else
          rsp_p     <= w_p;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
`endif
        end
`ifdef MULT_PIPE_EN
        CALC2: begin
          rsp_p     <= r_p;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
`endif
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
